// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch sequencer. Drives the PC-register enable, runs a single
//   outstanding req/ack transaction against a variable-latency instruction
//   memory, and hands fetched words to decode through an output slot backed
//   by a one-entry skid register. Any control-flow redirect squashes the
//   wrong-path fetch and flushes slot and skid.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : an outstanding request is aborted after TIMEOUT cycles and
//                 the sticky fetch_err_o flag is raised.
//     undefined : requests wait indefinitely, fetch_err_o is tied low.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   pc_i          current PC register value
//   redirect_i    jump/branch/jump-register redirect from decode
//   id_stall_i    decode cannot accept an instruction this cycle
//   pc_en_o       PC register enable (combinational)
//   imem_req_o    memory request (registered)
//   imem_addr_o   request address, stable while imem_req_o=1
//   imem_ack_i    memory response valid (honoured only while imem_req_o=1)
//   imem_rdata_i  instruction word returned with imem_ack_i
//   instr_valid_o instr_o / instr_pc_o valid for decode
//   instr_o       fetched instruction
//   instr_pc_o    address of instr_o
//   fetch_err_o   sticky timeout flag
module fetch_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic        id_stall_i,
    output logic        pc_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        slot_vld_q, slot_vld_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic ack;
    logic consume;
    logic deliver;
    logic can_launch;
    logic launch;
    logic pc_en;
    logic timeout;

    // An ack is only meaningful while our own request is on the bus.
    assign ack     = imem_ack_i & req_q;
    assign consume = slot_vld_q & ~id_stall_i;
    assign deliver = ack & ~redirect_i & (state_q == S_WAIT);

    // Slot/skid update. A consumed slot is refilled from the skid first so
    // that older data always reaches decode ahead of a fresh response.
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (redirect_i) begin
            slot_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (consume) begin
            if (skid_vld_q) begin
                slot_instr_d = skid_instr_q;
                slot_pc_d    = skid_pc_q;
                skid_vld_d   = deliver;
                if (deliver) begin
                    skid_instr_d = imem_rdata_i;
                    skid_pc_d    = addr_q;
                end
            end else begin
                slot_vld_d = deliver;
                if (deliver) begin
                    slot_instr_d = imem_rdata_i;
                    slot_pc_d    = addr_q;
                end
            end
        end else if (deliver) begin
            if (slot_vld_q) begin
                skid_vld_d   = 1'b1;
                skid_instr_d = imem_rdata_i;
                skid_pc_d    = addr_q;
            end else begin
                slot_vld_d   = 1'b1;
                slot_instr_d = imem_rdata_i;
                slot_pc_d    = addr_q;
            end
        end
    end

    // A new fetch may only start if its response is guaranteed a place.
    assign can_launch = ~skid_vld_d;

`ifdef FETCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q;

    assign timeout = (state_q != S_IDLE) & ~ack & (cnt_q >= TIMEOUT_W'(TIMEOUT - 1));
    assign cnt_d   = (launch || ack || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!redirect_i && can_launch) state_d = S_WAIT;
            S_WAIT: begin
                if (ack)             state_d = (!redirect_i && can_launch) ? S_WAIT : S_IDLE;
                else if (timeout)    state_d = S_IDLE;
                else if (redirect_i) state_d = S_DROP;
            end
            S_DROP: if (ack || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: a redirect always enables the PC register and blocks launch.
    always_comb begin
        pc_en  = 1'b0;
        launch = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_en  = redirect_i | can_launch;
                launch = ~redirect_i & can_launch;
            end
            S_WAIT: begin
                pc_en  = redirect_i | (ack & can_launch);
                launch = ~redirect_i & ack & can_launch;
            end
            S_DROP: pc_en = redirect_i;
            default: ;
        endcase
    end

    assign pc_en_o = pc_en & rst_ni;

    assign req_d  = launch | (req_q & (state_d != S_IDLE));
    assign addr_d = launch ? pc_i : addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q        <= 1'b0;
            addr_q       <= '0;
            slot_vld_q   <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            req_q        <= req_d;
            addr_q       <= addr_d;
            slot_vld_q   <= slot_vld_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = slot_vld_q;
    assign instr_o       = slot_instr_q;
    assign instr_pc_o    = slot_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a behavioural memory pushes every response
// that should survive into a scoreboard queue; a monitor checks decode-side
// outputs against the queue and against the expected address sequence.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        redirect;
    logic        id_stall;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;
    logic [31:0] tgt;

    fetch_sequencer #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_i          (pc),
        .redirect_i    (redirect),
        .id_stall_i    (id_stall),
        .pc_en_o       (pc_en),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .fetch_err_o   (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_cons = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Memory model (drives at negedge+1)
    int          mem_lat   = 0;
    bit          mem_off   = 0;
    bit          force_ack = 0;
    int          mem_wcnt  = 0;
    bit          mem_squash = 0;
    bit          push_vld  = 0;
    logic [31:0] push_pc, push_data;

    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            push_vld   = 0;
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (force_ack) begin
                imem_ack = 1'b1;
            end else if (!rst_n || !imem_req) begin
                mem_wcnt   = 0;
                mem_squash = 0;
            end else if (mem_off) begin
                mem_squash = mem_squash | redirect;
            end else if (mem_wcnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = fmem(imem_addr);
                if (!(mem_squash || redirect)) begin
                    push_vld  = 1;
                    push_pc   = imem_addr;
                    push_data = fmem(imem_addr);
                end
                mem_wcnt   = 0;
                mem_squash = 0;
            end else begin
                mem_wcnt++;
                mem_squash = mem_squash | redirect;
            end
        end
    end

    // Scoreboard monitor (negedge+2)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    logic [31:0] exp_next = RST_PC;
    logic        pc_en_s  = 1'b0;
    logic        redir_s  = 1'b0;
    logic [31:0] tgt_s    = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                q.delete();
                exp_next = RST_PC;
                pc_en_s  = 1'b0;
                redir_s  = 1'b0;
            end else begin
                check("valid", instr_valid, q.size() != 0);
                if (instr_valid && q.size() != 0) begin
                    check("slot_pc", instr_pc, q[0].pc);
                    check("slot_instr", instr, q[0].data);
                end
                if (instr_valid && !id_stall) begin
                    n_cons++;
                    check("order", instr_pc, exp_next);
                    check("idata", instr, fmem(instr_pc));
                    exp_next = exp_next + 32'd4;
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (redirect) begin
                    q.delete();
                    exp_next = tgt;
                end
                if (push_vld) q.push_back('{pc: push_pc, data: push_data});
                check("depth", q.size() <= 2, 1);
                pc_en_s = pc_en;
                redir_s = redirect;
                tgt_s   = tgt;
            end
        end
    end

    // PC register model is advanced at the start of every cycle.
    task automatic cyc();
        @(negedge clk);
        if (!rst_n)       pc = RST_PC;
        else if (pc_en_s) pc = redir_s ? tgt_s : pc + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        bit saw_low;
        int c0;
        int hi;
        rst_n = 1'b0; redirect = 1'b0; id_stall = 1'b0; tgt = '0; pc = RST_PC;
        force_ack = 1;

        // Reset state, with a stray ack held during reset
        repeat (3) cyc();
        #3;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_err", fetch_err, 0);
        check("rst_pcen", pc_en, 0);

        // First launch and streaming
        cyc(); force_ack = 0; rst_n = 1'b1; #3;
        check("first_pcen", pc_en, 1);
        check("first_req_low", imem_req, 0);
        cyc(); #3;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, RST_PC);
        check("b2b_pcen", pc_en, 1);
        cyc(); #3;
        check("first_valid", instr_valid, 1);
        check("first_ipc", instr_pc, RST_PC);
        check("second_addr", imem_addr, RST_PC + 32'd4);
        c0 = n_cons;
        repeat (8) begin cyc(); #3; end
        check("throughput", n_cons - c0, 8);

        // Decode stall fills slot and skid, then drains in order
        cyc(); id_stall = 1'b1; #3;
        repeat (5) begin cyc(); #3; end
        check("stall_req", imem_req, 0);
        check("stall_pcen", pc_en, 0);
        check("stall_valid", instr_valid, 1);
        cyc(); id_stall = 1'b0; #3;
        check("release_pcen", pc_en, 1);
        repeat (4) begin cyc(); #3; end

        // Redirect while slot and skid are both full
        cyc(); id_stall = 1'b1; #3;
        repeat (3) begin cyc(); #3; end
        cyc(); redirect = 1'b1; tgt = 32'h0060_0000; #3;
        check("full_redir_pcen", pc_en, 1);
        cyc(); redirect = 1'b0; #3;
        check("full_redir_valid", instr_valid, 0);
        check("full_redir_launch", pc_en, 1);
        cyc(); id_stall = 1'b0; #3;
        check("full_redir_addr", imem_addr, 32'h0060_0000);
        check("full_redir_req", imem_req, 1);
        repeat (4) begin cyc(); #3; end

        // Redirect while waiting, late ack discarded
        cyc(); mem_lat = 4; #3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (mem_wcnt == 1) begin found = 1; break; end
            #3;
        end
        check("wait_sync", found, 1);
        redirect = 1'b1; tgt = 32'h0050_0000; #3;
        check("wait_redir_pcen", pc_en, 1);
        check("wait_redir_req", imem_req, 1);
        cyc(); redirect = 1'b0; #3;
        check("drop_req_held", imem_req, 1);
        check("drop_pcen", pc_en, 0);
        found = 0; saw_low = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(); #3;
            if (!imem_req) saw_low = 1;
            else if (saw_low) begin found = 1; break; end
        end
        check("drop_relaunch", found, 1);
        check("drop_new_addr", imem_addr, 32'h0050_0000);
        cyc(); mem_lat = 0; #3;
        repeat (6) begin cyc(); #3; end

        // Redirect in the same cycle as an ack, slot full
        cyc(); id_stall = 1'b1; mem_lat = 2; #3;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (imem_req && mem_wcnt == mem_lat && instr_valid) begin found = 1; break; end
            #3;
        end
        check("ackredir_sync", found, 1);
        redirect = 1'b1; tgt = 32'h0070_0000; #3;
        check("ackredir_pcen", pc_en, 1);
        cyc(); redirect = 1'b0; #3;
        check("ackredir_valid", instr_valid, 0);
        check("ackredir_idle", imem_req, 0);
        check("ackredir_launch", pc_en, 1);
        cyc(); id_stall = 1'b0; mem_lat = 0; #3;
        check("ackredir_addr", imem_addr, 32'h0070_0000);
        repeat (6) begin cyc(); #3; end

        // Reset in the middle of an outstanding request
        cyc(); mem_lat = 5; #3;
        repeat (2) begin cyc(); #3; end
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (imem_req) begin found = 1; break; end
            #3;
        end
        check("midrst_sync", found, 1);
        rst_n = 1'b0; force_ack = 1; pc = RST_PC; #3;
        check("midrst_req", imem_req, 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_valid", instr_valid, 0);
        check("midrst_instr", instr, 0);
        check("midrst_pcen", pc_en, 0);
        cyc(); #3;
        cyc(); force_ack = 0; rst_n = 1'b1; mem_lat = 0; #3;
        check("postrst_pcen", pc_en, 1);
        cyc(); #3;
        check("postrst_req", imem_req, 1);
        check("postrst_addr", imem_addr, RST_PC);
        repeat (6) begin cyc(); #3; end

        // Memory stops acking
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (imem_req) begin found = 1; break; end
            #3;
        end
        check("to_sync", found, 1);
        mem_off = 1; #3;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req) hi++;
            else break;
            cyc(); #3;
        end
`ifdef FETCH_TIMEOUT_EN
        check("to_req_cycles", hi, 4);
        check("to_err", fetch_err, 1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!imem_req) begin found = 1; break; end
            #3;
        end
        check("to_low_sync", found, 1);
        force_ack = 1; #3;
        cyc(); force_ack = 0; #3;
        check("stray_valid", instr_valid, 0);
        repeat (3) begin cyc(); #3; end
        check("to_err_sticky", fetch_err, 1);
`else
        check("noto_req_cycles", hi, 12);
        check("noto_err", fetch_err, 0);
        check("noto_req", imem_req, 1);
`endif
        check("end_sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
